partition_fill_ctrl: RTL and testbench

- Parametrised next-generation partition stage of the iterative median (quickselect) datapath.
- Accepts one burst of cfg_size samples and classifies each sample against a sampled pivot.
- Classes are lower, equal and larger. Per-class counts and lower/larger min/max are tracked.
- After the burst, reports which region holds the target rank, the rank within that region, the region size, and whether the selected value is already resolved.
- Sits between the pixel FIFO and the pivot/recursion controller. Replaces the fixed 8-bit fill stage with an explicit start/done handshake.

---
 rtl/partition_fill_ctrl.sv | 151 +++++++++++++++
 tb/tb_partition_fill_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/partition_fill_ctrl.sv
// Partition stage for the iterative median (quickselect) datapath.
// Classifies one burst of samples against a pivot and reports the region that holds the target rank.
module partition_fill_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BUFF_SIZE = 32,
  parameter int CNT_W     = $clog2(BUFF_SIZE) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_pivot,
  input  logic [CNT_W-1:0]  cfg_size,
  input  logic [CNT_W-1:0]  cfg_rank,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  input  logic              res_ack,
  output logic [CNT_W-1:0]  lower_size,
  output logic [CNT_W-1:0]  equal_size,
  output logic [CNT_W-1:0]  larger_size,
  output logic [DATA_W-1:0] min_lower,
  output logic [DATA_W-1:0] max_lower,
  output logic [DATA_W-1:0] min_larger,
  output logic [DATA_W-1:0] max_larger,
  output logic [1:0]        sel_region,
  output logic [CNT_W-1:0]  next_rank,
  output logic [CNT_W-1:0]  next_size,
  output logic              resolved,
  output logic [DATA_W-1:0] result_value
);

  // state  | meaning
  // IDLE   | waiting for start with nonzero size; previous results held
  // FILL   | accepting and classifying samples
  // RESULT | results valid, waiting for res_ack
  typedef enum logic [1:0] {IDLE, FILL, RESULT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] pivot_q;
  logic [CNT_W-1:0]  rank_q;
  logic [CNT_W-1:0]  remain_q;
  logic [CNT_W-1:0]  rank_clamped;
  logic [CNT_W-1:0]  le_sum;
  logic              accept_start;
  logic              beat;
  logic              last_beat;

  assign accept_start = (state == IDLE) && start && (cfg_size != '0);
  assign beat         = (state == FILL) && in_valid;
  assign last_beat    = beat && (remain_q == CNT_W'(1));
  assign rank_clamped = (cfg_rank >= cfg_size) ? (cfg_size - CNT_W'(1)) : cfg_rank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept_start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (last_beat) state_nxt = RESULT;
      end
      RESULT: begin
        done = 1'b1;
        if (res_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // remain_q counts down the beats still owed; the beat seen at 1 closes the burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pivot_q     <= '0;
      rank_q      <= '0;
      remain_q    <= '0;
      lower_size  <= '0;
      equal_size  <= '0;
      larger_size <= '0;
      min_lower   <= '1;
      max_lower   <= '0;
      min_larger  <= '1;
      max_larger  <= '0;
    end else if (accept_start) begin
      pivot_q     <= cfg_pivot;
      rank_q      <= rank_clamped;
      remain_q    <= cfg_size;
      lower_size  <= '0;
      equal_size  <= '0;
      larger_size <= '0;
      min_lower   <= '1;
      max_lower   <= '0;
      min_larger  <= '1;
      max_larger  <= '0;
    end else if (beat) begin
      remain_q <= remain_q - CNT_W'(1);
      if (in_data < pivot_q) begin
        lower_size <= lower_size + CNT_W'(1);
        if (in_data < min_lower) min_lower <= in_data;
        if (in_data > max_lower) max_lower <= in_data;
      end else if (in_data == pivot_q) begin
        equal_size <= equal_size + CNT_W'(1);
      end else begin
        larger_size <= larger_size + CNT_W'(1);
        if (in_data < min_larger) min_larger <= in_data;
        if (in_data > max_larger) max_larger <= in_data;
      end
    end
  end

  assign le_sum = lower_size + equal_size;

  always_comb begin
    sel_region   = 2'b10;
    next_rank    = rank_q - le_sum;
    next_size    = larger_size;
    resolved     = 1'b0;
    result_value = '0;
    if (rank_q < lower_size) begin
      sel_region = 2'b00;
      next_rank  = rank_q;
      next_size  = lower_size;
      if (min_lower == max_lower) begin
        resolved     = 1'b1;
        result_value = min_lower;
      end
    end else if (rank_q < le_sum) begin
      sel_region   = 2'b01;
      next_rank    = rank_q - lower_size;
      next_size    = equal_size;
      resolved     = 1'b1;
      result_value = pivot_q;
    end else if (min_larger == max_larger) begin
      resolved     = 1'b1;
      result_value = min_larger;
    end
  end

endmodule

// File: tb/tb_partition_fill_ctrl.sv
// Directed bench for partition_fill_ctrl: default 8-bit instance plus a 12-bit/64-deep instance.
module tb_partition_fill_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic       start = 0, in_valid = 0, res_ack = 0;
  logic [7:0] cfg_pivot = 0, in_data = 0;
  logic [5:0] cfg_size = 0, cfg_rank = 0;
  logic       in_ready, busy, done, resolved;
  logic [5:0] lower_size, equal_size, larger_size, next_rank, next_size;
  logic [7:0] min_lower, max_lower, min_larger, max_larger, result_value;
  logic [1:0] sel_region;

  logic        w_start = 0, w_in_valid = 0, w_res_ack = 0;
  logic [11:0] w_cfg_pivot = 0, w_in_data = 0;
  logic [6:0]  w_cfg_size = 0, w_cfg_rank = 0;
  logic        w_in_ready, w_busy, w_done, w_resolved;
  logic [6:0]  w_lower_size, w_equal_size, w_larger_size, w_next_rank, w_next_size;
  logic [11:0] w_min_lower, w_max_lower, w_min_larger, w_max_larger, w_result_value;
  logic [1:0]  w_sel_region;

  partition_fill_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pivot(cfg_pivot), .cfg_size(cfg_size),
    .cfg_rank(cfg_rank), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .res_ack(res_ack), .lower_size(lower_size),
    .equal_size(equal_size), .larger_size(larger_size), .min_lower(min_lower),
    .max_lower(max_lower), .min_larger(min_larger), .max_larger(max_larger),
    .sel_region(sel_region), .next_rank(next_rank), .next_size(next_size),
    .resolved(resolved), .result_value(result_value)
  );

  partition_fill_ctrl #(.DATA_W(12), .BUFF_SIZE(64)) u_wide (
    .clk(clk), .rst_n(rst_n), .start(w_start), .cfg_pivot(w_cfg_pivot), .cfg_size(w_cfg_size),
    .cfg_rank(w_cfg_rank), .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .busy(w_busy), .done(w_done), .res_ack(w_res_ack), .lower_size(w_lower_size),
    .equal_size(w_equal_size), .larger_size(w_larger_size), .min_lower(w_min_lower),
    .max_lower(w_max_lower), .min_larger(w_min_larger), .max_larger(w_max_larger),
    .sel_region(w_sel_region), .next_rank(w_next_rank), .next_size(w_next_size),
    .resolved(w_resolved), .result_value(w_result_value)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    in_data  = d;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic ack();
    res_ack = 1;
    tick();
    res_ack = 0;
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_lower", lower_size, 0);
    chk("rst_min_lower", min_lower, 8'hFF);
    chk("rst_max_larger", max_larger, 0);
    rst_n = 1;
    tick();

    // pass 1: pivot 100, size 5, rank 2
    start = 1; cfg_pivot = 100; cfg_size = 5; cfg_rank = 2;
    tick();
    start = 0;
    chk("p1_in_ready", in_ready, 1);
    chk("p1_busy", busy, 1);
    send(50); send(100); send(150); send(20);
    chk("p1_done_early", done, 0);
    send(100);
    chk("p1_done", done, 1);
    chk("p1_in_ready_off", in_ready, 0);
    chk("p1_L", lower_size, 2);
    chk("p1_E", equal_size, 2);
    chk("p1_G", larger_size, 1);
    chk("p1_min_lower", min_lower, 20);
    chk("p1_max_lower", max_lower, 50);
    chk("p1_min_larger", min_larger, 150);
    chk("p1_sel", sel_region, 2'b01);
    chk("p1_next_rank", next_rank, 0);
    chk("p1_next_size", next_size, 2);
    chk("p1_resolved", resolved, 1);
    chk("p1_value", result_value, 100);

    // hold without ack, with a start attempt in RESULT
    start = 1; cfg_pivot = 3; cfg_size = 7; cfg_rank = 0;
    for (int i = 0; i < 10; i++) tick();
    start = 0;
    chk("hold_done", done, 1);
    chk("hold_L", lower_size, 2);
    chk("hold_sel", sel_region, 2'b01);
    chk("hold_value", result_value, 100);
    ack();
    chk("ack_done", done, 0);
    chk("ack_busy", busy, 0);
    chk("ack_keep_L", lower_size, 2);
    chk("ack_keep_value", result_value, 100);

    // pass 2: pivot 10, size 4, rank 3, gaps and a start during FILL
    start = 1; cfg_pivot = 10; cfg_size = 4; cfg_rank = 3;
    tick();
    send(1);
    start = 1; cfg_pivot = 0; cfg_size = 2; cfg_rank = 0;
    tick();
    start = 0;
    chk("p2_gap_ready", in_ready, 1);
    chk("p2_gap_L", lower_size, 1);
    send(2);
    tick();
    send(30);
    in_data = 40; in_valid = 1;
    tick();
    chk("p2_done", done, 1);
    chk("p2_in_ready_off", in_ready, 0);
    in_data = 5;
    tick();
    in_valid = 0;
    chk("p2_L", lower_size, 2);
    chk("p2_G", larger_size, 2);
    chk("p2_sel", sel_region, 2'b10);
    chk("p2_next_rank", next_rank, 1);
    chk("p2_next_size", next_size, 2);
    chk("p2_min_larger", min_larger, 30);
    chk("p2_max_larger", max_larger, 40);
    chk("p2_resolved", resolved, 0);
    chk("p2_value", result_value, 0);
    ack();

    // pass 3: pivot 200, size 3, rank 1, all 7
    start = 1; cfg_pivot = 200; cfg_size = 3; cfg_rank = 1;
    tick();
    start = 0;
    send(7); send(7); send(7);
    chk("p3_sel", sel_region, 2'b00);
    chk("p3_next_rank", next_rank, 1);
    chk("p3_next_size", next_size, 3);
    chk("p3_resolved", resolved, 1);
    chk("p3_value", result_value, 7);
    chk("p3_empty_min", min_larger, 8'hFF);
    chk("p3_empty_max", max_larger, 0);
    ack();

    // pass 4: rank 9 clamped to 3 with size 4
    start = 1; cfg_pivot = 50; cfg_size = 4; cfg_rank = 9;
    tick();
    start = 0;
    send(10); send(20); send(60); send(70);
    chk("p4_sel", sel_region, 2'b10);
    chk("p4_next_rank", next_rank, 1);
    chk("p4_next_size", next_size, 2);
    chk("p4_resolved", resolved, 0);
    ack();

    // start with size 0 is ignored
    start = 1; cfg_size = 0; cfg_rank = 0;
    tick();
    start = 0;
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_busy2", busy, 0);
    chk("zero_keep_L", lower_size, 2);

    // wide instance: 64 beats of 0xFFF, pivot 0x800, rank 10
    w_start = 1; w_cfg_pivot = 12'h800; w_cfg_size = 64; w_cfg_rank = 10;
    tick();
    w_start = 0;
    w_in_data = 12'hFFF; w_in_valid = 1;
    for (int i = 0; i < 63; i++) tick();
    chk("w_done_early", w_done, 0);
    tick();
    w_in_valid = 0;
    chk("w_done", w_done, 1);
    chk("w_G", w_larger_size, 64);
    chk("w_min_larger", w_min_larger, 12'hFFF);
    chk("w_max_larger", w_max_larger, 12'hFFF);
    chk("w_sel", w_sel_region, 2'b10);
    chk("w_next_rank", w_next_rank, 10);
    chk("w_next_size", w_next_size, 64);
    chk("w_resolved", w_resolved, 1);
    chk("w_value", w_result_value, 12'hFFF);
    w_res_ack = 1; tick(); w_res_ack = 0;

    // reset after 30 beats discards the partial burst
    w_start = 1;
    tick();
    w_start = 0;
    w_in_valid = 1;
    for (int i = 0; i < 30; i++) tick();
    chk("w_mid_G", w_larger_size, 30);
    rst_n = 0;
    #2;
    chk("w_rst_busy", w_busy, 0);
    chk("w_rst_ready", w_in_ready, 0);
    chk("w_rst_G", w_larger_size, 0);
    chk("w_rst_min", w_min_larger, 12'hFFF);
    chk("w_rst_max", w_max_larger, 0);
    chk("n_rst_L", lower_size, 0);
    w_in_valid = 0;
    rst_n = 1;
    tick();

    // clean pass after reset: 0x100, 0x900, 0x800 around pivot 0x800, rank 0
    w_start = 1; w_cfg_pivot = 12'h800; w_cfg_size = 3; w_cfg_rank = 0;
    tick();
    w_start = 0;
    w_in_valid = 1;
    w_in_data = 12'h100; tick();
    w_in_data = 12'h900; tick();
    w_in_data = 12'h800; tick();
    w_in_valid = 0;
    chk("w2_done", w_done, 1);
    chk("w2_L", w_lower_size, 1);
    chk("w2_E", w_equal_size, 1);
    chk("w2_G", w_larger_size, 1);
    chk("w2_sel", w_sel_region, 2'b00);
    chk("w2_next_size", w_next_size, 1);
    chk("w2_value", w_result_value, 12'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
